// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: fetch-side SRAM-like port to AXI AR/R bridge.
// Ports: inst_sram_* (fetch request/response), outst_cnt, proto_err,
//        ar* (AXI read address channel), r* (AXI read data channel).
module inst_axi_rd_bridge #(
    parameter logic [3:0] AR_ID     = 4'd0,
    parameter int         MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_rerr,
    output logic [1:0]  outst_cnt,
    output logic        proto_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BUSY  = 1'b1;
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

    logic [0:0]  state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;
    logic        perr_q, perr_d;

    logic acc;
    logic beat_ok;
    logic beat_stray;

    // Write-side fields, rid and rlast carry no information here.
    logic unused_in;
    assign unused_in = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    // R is always accepted so a stray beat can never wedge the bus.
    assign rready = 1'b1;

    always_comb begin
        // resetn gating keeps addr_ok low while the bridge is held in reset
        acc = resetn & inst_sram_req & ~inst_sram_wr
            & (~arvalid | arready) & (cnt_q < MAX_CNT);
        beat_ok    = rvalid & rready & (cnt_q != 2'd0);
        beat_stray = rvalid & rready & (cnt_q == 2'd0) & ~arvalid;

        state_d  = state_q;
        araddr_d = araddr_q;
        size_d   = size_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d  = S_BUSY;
                    araddr_d = inst_sram_addr;
                    size_d   = inst_sram_size;
                end
            end
            S_BUSY: begin
                // acc in BUSY implies arready: back-to-back reload
                if (acc) begin
                    araddr_d = inst_sram_addr;
                    size_d   = inst_sram_size;
                end else if (arready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d     = cnt_q + {1'b0, acc} - {1'b0, beat_ok};
        data_ok_d = beat_ok;
        rdata_d   = beat_ok ? rdata : rdata_q;
        rerr_d    = beat_ok ? (rresp != 2'b00) : rerr_q;
        perr_d    = perr_q | beat_stray;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            araddr_q  <= 32'd0;
            size_q    <= 2'd0;
            cnt_q     <= 2'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            rerr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            perr_q    <= perr_d;
        end
    end

    assign inst_sram_addr_ok = acc;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign inst_rerr         = rerr_q;
    assign outst_cnt         = cnt_q;
    assign proto_err         = perr_q;

    assign arvalid = (state_q == S_BUSY);
    assign arid    = AR_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb_inst_axi_rd_bridge: randomized + directed bench for inst_axi_rd_bridge.
// A queue-based reference model and an AXI slave model live in the bench.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_rerr, proto_err;
    logic [1:0]  outst_cnt;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.AR_ID(4'd0), .MAX_OUTST(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .inst_rerr(inst_rerr),
        .outst_cnt(outst_cnt), .proto_err(proto_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus controls
    logic        t_rstn, t_req, t_wr, t_rand, t_err_force, t_stray_force;
    logic [1:0]  t_size;
    logic [31:0] t_addr;
    int          t_ar_mode, t_dmin, t_dmax, t_err_pct, t_stray_pct;

    // slave: addresses it owes a beat for, and the cycle each becomes due
    logic [31:0] sq_a[$];
    int          sq_t[$];

    // reference model
    logic        m_arv, m_dok, m_rerr, m_perr;
    logic [31:0] m_ar_addr, m_rdata;
    logic [1:0]  m_ar_size;
    int          m_cnt;
    logic [31:0] m_q[$];

    logic        last_aok;
    logic [31:0] got_q[$];

    function automatic logic [31:0] sdat(input logic [31:0] a);
        if (a == 32'h1c00_0000) return 32'h0280_0c00;
        return (a ^ 32'hdead_0000) + 32'd3;
    endfunction

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h (cyc %0d)", n, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_arv = 1'b0; m_dok = 1'b0; m_rerr = 1'b0; m_perr = 1'b0;
        m_ar_addr = 32'd0; m_rdata = 32'd0; m_ar_size = 2'd0;
        m_cnt = 0;
        m_q.delete();
    endtask

    task automatic step();
        logic exp_acc, real_beat, dok;
        @(negedge clk);
        chk("arvalid", 32'(arvalid), 32'(m_arv));
        chk("araddr", araddr, m_ar_addr);
        chk("arsize", 32'(arsize), 32'({1'b0, m_ar_size}));
        chk("outst_cnt", 32'(outst_cnt), 32'(m_cnt));
        chk("data_ok", 32'(inst_sram_data_ok), 32'(m_dok));
        chk("rdata", inst_sram_rdata, m_rdata);
        chk("rerr", 32'(inst_rerr), 32'(m_rerr));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        if (inst_sram_data_ok) got_q.push_back(inst_sram_rdata);

        if (t_rand) begin
            t_req  = ($urandom_range(0, 9) < 7);
            t_wr   = ($urandom_range(0, 9) == 0);
            t_size = 2'($urandom_range(0, 2));
            t_addr = $urandom & 32'hffff_fffc;
        end
        resetn          = t_rstn;
        inst_sram_req   = t_req;
        inst_sram_wr    = t_wr;
        inst_sram_size  = t_size;
        inst_sram_addr  = t_addr;
        inst_sram_wstrb = 4'($urandom);
        inst_sram_wdata = $urandom;
        arready = (t_ar_mode == 2) ? ($urandom_range(0, 1) == 1)
                                   : (t_ar_mode == 1);
        real_beat = 1'b0;
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
        rid    = 4'($urandom);
        rlast  = 1'($urandom);
        if (sq_a.size() > 0 && sq_t[0] <= cyc) begin
            rvalid = 1'b1;
            real_beat = 1'b1;
            rdata = sdat(sq_a[0]);
            if (t_err_force) rresp = 2'b10;
            else if ($urandom_range(0, 99) < t_err_pct)
                rresp = 2'($urandom_range(1, 3));
            else rresp = 2'b00;
        end else if (t_stray_force ||
                     (m_cnt == 0 && !m_arv && sq_a.size() == 0 &&
                      $urandom_range(0, 99) < t_stray_pct)) begin
            rvalid = 1'b1;
        end
        #1;
        exp_acc = t_rstn && t_req && !t_wr && (!m_arv || arready)
                  && (m_cnt < 2);
        last_aok = inst_sram_addr_ok;
        chk("addr_ok", 32'(inst_sram_addr_ok), 32'(exp_acc));
        chk("rready", 32'(rready), 32'd1);
        chk("ar_const", 32'({arid, arlen, arburst, arlock, arcache, arprot}),
            32'({4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));

        if (real_beat) begin
            sq_a.delete(0);
            sq_t.delete(0);
        end
        if (arvalid && arready) begin
            sq_a.push_back(araddr);
            sq_t.push_back(cyc + int'($urandom_range(t_dmin, t_dmax)));
        end

        if (!t_rstn) begin
            model_reset();
        end else begin
            dok = rvalid && (m_cnt != 0);
            if (rvalid && m_cnt == 0) m_perr = 1'b1;
            m_dok = dok;
            if (dok) begin
                m_rerr  = (rresp != 2'b00);
                m_rdata = sdat(m_q.pop_front());
            end
            if (exp_acc) begin
                m_q.push_back(t_addr);
                m_ar_addr = t_addr;
                m_ar_size = t_size;
                m_arv = 1'b1;
            end else if (arready) begin
                m_arv = 1'b0;
            end
            m_cnt = m_cnt + (exp_acc ? 1 : 0) - (dok ? 1 : 0);
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        t_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int blocked;
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0;
        inst_sram_wdata = 32'd0; arready = 1'b0; rvalid = 1'b0;
        rdata = 32'd0; rresp = 2'd0; rid = 4'd0; rlast = 1'b0;
        t_rstn = 1'b0; t_req = 1'b1; t_wr = 1'b0; t_rand = 1'b0;
        t_size = 2'd2; t_addr = 32'h40;
        t_err_force = 1'b0; t_stray_force = 1'b0;
        t_ar_mode = 1; t_dmin = 1; t_dmax = 1;
        t_err_pct = 0; t_stray_pct = 0;
        model_reset();

        // reset state, with a request held active throughout
        for (int i = 0; i < 3; i++) step();
        chk("rst_addr_ok", 32'(last_aok), 32'd0);
        #1;
        chk("rst_state", 32'({arvalid, outst_cnt, inst_sram_data_ok,
                              inst_rerr, proto_err}), 32'd0);
        chk("rst_rdata", inst_sram_rdata, 32'd0);
        t_rstn = 1'b1;
        idle(2);

        // single fetch, best-case latency
        t_req = 1'b1; t_addr = 32'h1c00_0000; t_size = 2'd2;
        step();
        chk("s1_addr_ok", 32'(last_aok), 32'd1);
        t_req = 1'b0;
        #1;
        chk("s1_arvalid", 32'(arvalid), 32'd1);
        chk("s1_araddr", araddr, 32'h1c00_0000);
        chk("s1_arsize", 32'(arsize), 32'd2);
        step();
        step();
        #1;
        chk("s1_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("s1_rdata", inst_sram_rdata, 32'h0280_0c00);
        chk("s1_cnt", 32'(outst_cnt), 32'd0);
        idle(2);

        // AR backpressure
        t_ar_mode = 0; t_dmin = 1; t_dmax = 3;
        t_req = 1'b1; t_addr = 32'h200; t_size = 2'd2;
        step();
        t_addr = 32'h204;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_addr_ok", 32'(last_aok), 32'd0);
            #1;
            chk("bp_hold", {arvalid, araddr[30:0]}, {1'b1, 31'h200});
            chk("bp_cnt", 32'(outst_cnt), 32'd1);
        end
        t_ar_mode = 1;
        step();
        chk("bp_accept", 32'(last_aok), 32'd1);
        idle(10);

        // saturation at two outstanding, R delayed 5 cycles
        got_q.delete();
        t_dmin = 5; t_dmax = 5;
        t_req = 1'b1; t_addr = 32'h300; step();
        t_addr = 32'h304; step();
        t_addr = 32'h308;
        blocked = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_aok) break;
            blocked++;
        end
        chk("sat_blocked", 32'(blocked), 32'd5);
        idle(12);
        chk("sat_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() >= 2) begin
            chk("sat_first", got_q[0], 32'hdead_0303);
            chk("sat_second", got_q[1], 32'hdead_0307);
        end

        // accept and return in the same cycle at count 1
        t_dmin = 1; t_dmax = 1;
        t_req = 1'b1; t_addr = 32'h600; step();
        t_req = 1'b0; step();
        t_req = 1'b1; t_addr = 32'h604; step();
        chk("simul_acc", 32'(last_aok), 32'd1);
        t_req = 1'b0;
        #1;
        chk("simul_cnt", 32'(outst_cnt), 32'd1);
        idle(6);

        // error response
        t_err_force = 1'b1;
        t_req = 1'b1; t_addr = 32'h400; step();
        t_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            if (inst_sram_data_ok) break;
        end
        chk("err_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("err_rerr", 32'(inst_rerr), 32'd1);
        chk("err_rdata", inst_sram_rdata, 32'hdead_0403);
        t_err_force = 1'b0;
        idle(3);

        // illegal write
        t_req = 1'b1; t_wr = 1'b1; t_addr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_addr_ok", 32'(last_aok), 32'd0);
        end
        t_wr = 1'b0;
        idle(2);

        // stray beat while idle
        t_stray_force = 1'b1; step(); t_stray_force = 1'b0;
        #1;
        chk("stray_perr", 32'(proto_err), 32'd1);
        chk("stray_no_dok", 32'(inst_sram_data_ok), 32'd0);
        idle(2);

        // async reset mid-BUSY with two outstanding
        t_dmin = 8; t_dmax = 8;
        t_req = 1'b1; t_addr = 32'h700; step();
        t_addr = 32'h704; step();
        t_req = 1'b0;
        #2;
        resetn = 1'b0;
        t_rstn = 1'b0;
        #1;
        chk("arst_state", 32'({arvalid, outst_cnt, proto_err}), 32'd0);
        model_reset();
        idle(2);
        t_rstn = 1'b1;
        for (int i = 0; i < 30 && sq_a.size() > 0; i++) step();
        step();
        #1;
        chk("arst_stray_perr", 32'(proto_err), 32'd1);
        t_rstn = 1'b0; idle(2); t_rstn = 1'b1; idle(2);

        // randomized traffic
        t_ar_mode = 2; t_dmin = 1; t_dmax = 4;
        t_err_pct = 10; t_stray_pct = 3; t_rand = 1'b1;
        for (int i = 0; i < 3000; i++) step();
        t_rand = 1'b0; t_stray_pct = 0;
        idle(30);
        chk("drain_cnt", 32'(outst_cnt), 32'd0);
        chk("drain_q", 32'(m_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
Instruction-side bridge between the fetch stage's SRAM-like port and the AXI read channels (AR/R). It sits directly upstream of the fetch stage. It accepts fetch requests, issues single-beat AXI reads, and returns data in order as one-cycle data_ok pulses. It also exposes the in-flight request count so the fetch stage can manage cancellation.

Parameters:
- AR_ID, 4'd0, fixed arid for all instruction reads.
- MAX_OUTST, 2, maximum accepted-but-unreturned requests (1..3).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req  in  1  fetch request
- inst_sram_wr  in  1  write flag; must be 0
- inst_sram_size  in  2  log2 bytes
- inst_sram_addr  in  32  fetch address
- inst_sram_wstrb  in  4  unused, ignored
- inst_sram_wdata  in  32  unused, ignored
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- inst_rerr  out  1  rresp error, aligned with data_ok
- outst_cnt  out  2  accepted-not-returned count
- proto_err  out  1  sticky: R beat with nothing outstanding
- arid  out  4  =AR_ID
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, latched size}
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored (single ID, in-order)
- rdata  in  32  read data
- rresp  in  2  response code
- rlast  in  1  ignored (arlen=0)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset (async, resetn=0): arvalid=0, araddr=0, arsize=0, outst_cnt=0, inst_sram_data_ok=0, inst_sram_rdata=0, inst_rerr=0, proto_err=0, inst_sram_addr_ok=0.
- Accept condition (combinational):
  - acc = inst_sram_req & ~inst_sram_wr & (~arvalid | arready) & (outst_cnt < MAX_OUTST).
  - inst_sram_addr_ok = acc.
  - Requests with wr=1 are never accepted.
- AR slot, two states:
  - IDLE (arvalid=0): on acc, latch addr/size, go to BUSY (arvalid=1 next cycle).
  - BUSY: hold araddr/arsize stable until arready.
    - On arready & acc: load the new request and stay BUSY (back-to-back).
    - On arready & ~acc: go to IDLE.
- Outstanding counter:
  - +1 on acc; −1 on the R handshake.
  - Simultaneous +1/−1 leaves it unchanged.
  - Never wraps: acc is blocked at MAX_OUTST.
  - A decrement at 0 is suppressed.
- rready = 1 whenever outst_cnt ≠ 0 or arvalid; otherwise rready = 1 and beats are consumed as errors.
- Response path (registered):
  - On rvalid & rready & outst_cnt≠0: next cycle data_ok=1 for exactly one cycle, rdata registered, inst_rerr=(rresp≠2'b00).
  - Otherwise data_ok=0, and rdata holds its last value.
- Unexpected beat (rvalid with outst_cnt=0 and arvalid=0): beat is dropped, no data_ok, proto_err set sticky until reset.
- Latency: best case addr_ok at cycle T, arvalid at T+1, R beat at T+2, data_ok at T+3.
- In-order: data_ok pulses return in acceptance order. The bridge never reorders or drops an accepted request.
- Reset mid-transaction: all state clears immediately. In-flight AXI beats arriving after reset are treated as unexpected beats.

Test Plan:
- Single fetch: req addr=0x1c000000, size=2, arready=1, slave answers 1 cycle later with rdata=0x02800c00 -> addr_ok at T, arvalid/araddr=0x1c000000, arsize=3'b010 at T+1, data_ok with rdata=0x02800c00 at T+3, outst_cnt back to 0.
- Backpressure: arready=0 for 4 cycles -> arvalid and araddr held stable; second req gets no addr_ok until arready; outst_cnt=1 throughout.
- Saturation: MAX_OUTST=2, three back-to-back reqs, slave delays R 5 cycles -> first two addr_ok, third blocked until the first data_ok; data returned in order 0x...00, 0x...04.
- Simultaneous accept and return at outst_cnt=1 -> count stays 1.
- Error and illegal write: rresp=2'b10 -> data_ok with inst_rerr=1. req with wr=1 -> addr_ok never asserted. Stray rvalid at idle -> proto_err=1, no data_ok.
- Async reset asserted mid-BUSY with outst_cnt=2 -> arvalid=0, outst_cnt=0 without waiting for a clock edge. A later stray R beat sets proto_err.
